// File: rtl/ro_puf_controller.sv
// RO PUF challenge/response sequencer: steps the RO selector, runs the selected RO pair,
// counts synchronised edges over a fixed window and shifts one comparison bit per measurement.
module ro_puf_controller #(
  parameter int unsigned NUM_RO    = 8,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned WINDOW    = 1024,
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned RESP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           challenge,
  output logic [3:0]           sel_seed,
  output logic                 sel_step,
  input  logic [SEL_W-1:0]     ro1_sel,
  input  logic [SEL_W-1:0]     ro2_sel,
  input  logic [NUM_RO-1:0]    ro_tick,
  output logic [NUM_RO-1:0]    ro_run,
  output logic                 busy,
  output logic [RESP_BITS-1:0] response,
  output logic                 response_valid,
  output logic                 tie_flag,
  output logic                 collision_flag
);

  localparam int unsigned TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_LATCH, ST_SETTLE, ST_MEASURE, ST_COMPARE, ST_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer;
  logic [IDX_W-1:0]   bit_idx;
  logic [SEL_W-1:0]   idx_a, idx_b;
  logic [CNT_W-1:0]   cnt1, cnt2;
  logic [NUM_RO-1:0]  tick_s1, tick_s2, tick_d;
  logic [NUM_RO-1:0]  tick_rise;
  logic [NUM_RO-1:0]  sel_mask, idx_mask, run_nxt;
  logic               last_bit;

  assign tick_rise = tick_s2 & ~tick_d;
  assign sel_mask  = (NUM_RO'(1) << ro1_sel) | (NUM_RO'(1) << ro2_sel);
  assign idx_mask  = (NUM_RO'(1) << idx_a) | (NUM_RO'(1) << idx_b);
  assign last_bit  = (bit_idx == IDX_W'(RESP_BITS - 1));

  // Two-flop synchroniser plus a delay flop for rising-edge detection of the RO taps
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_s1 <= '0;
      tick_s2 <= '0;
      tick_d  <= '0;
    end else begin
      tick_s1 <= ro_tick;
      tick_s2 <= tick_s1;
      tick_d  <= tick_s2;
    end
  end

  // Next-state and next ro_run value
  always_comb begin
    state_nxt = state;
    run_nxt   = '0;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_SELECT;
      ST_SELECT:  state_nxt = ST_LATCH;
      ST_LATCH:   state_nxt = ST_SETTLE;
      ST_SETTLE:  if (timer == '0) state_nxt = ST_MEASURE;
      ST_MEASURE: if (timer == '0) state_nxt = ST_COMPARE;
      ST_COMPARE: state_nxt = last_bit ? ST_DONE : ST_SELECT;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    // idx_a/idx_b are only being captured on the LATCH edge, so use the selector outputs there
    if (state_nxt == ST_SETTLE || state_nxt == ST_MEASURE)
      run_nxt = (state == ST_LATCH) ? sel_mask : idx_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      timer          <= '0;
      bit_idx        <= '0;
      idx_a          <= '0;
      idx_b          <= '0;
      cnt1           <= '0;
      cnt2           <= '0;
      sel_seed       <= '0;
      sel_step       <= 1'b0;
      ro_run         <= '0;
      busy           <= 1'b0;
      response       <= '0;
      response_valid <= 1'b0;
      tie_flag       <= 1'b0;
      collision_flag <= 1'b0;
    end else begin
      state          <= state_nxt;
      sel_step       <= (state_nxt == ST_SELECT);
      busy           <= (state_nxt != ST_IDLE);
      response_valid <= (state_nxt == ST_DONE);
      ro_run         <= run_nxt;

      // Single phase timer, reloaded on every state change
      if (state_nxt != state)
        timer <= (state_nxt == ST_SETTLE) ? TMR_W'(SETTLE - 1) : TMR_W'(WINDOW - 1);
      else if (timer != '0)
        timer <= timer - TMR_W'(1);

      case (state)
        ST_IDLE: begin
          if (start) begin
            sel_seed       <= challenge;
            tie_flag       <= 1'b0;
            collision_flag <= 1'b0;
            response       <= '0;
            bit_idx        <= '0;
          end
        end
        ST_LATCH: begin
          idx_a <= ro1_sel;
          idx_b <= ro2_sel;
          cnt1  <= '0;
          cnt2  <= '0;
          if (ro1_sel == ro2_sel) collision_flag <= 1'b1;
        end
        ST_MEASURE: begin
          if (tick_rise[idx_a] && cnt1 != CNT_MAX) cnt1 <= cnt1 + CNT_W'(1);
          if (tick_rise[idx_b] && cnt2 != CNT_MAX) cnt2 <= cnt2 + CNT_W'(1);
        end
        ST_COMPARE: begin
          // First measured bit ends up as the MSB
          response <= RESP_BITS'({response, (cnt1 > cnt2)});
          if (cnt1 == cnt2) tie_flag <= 1'b1;
          if (!last_bit) bit_idx <= bit_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_controller.sv
// Bench for ro_puf_controller: selector and RO bank modelled here, responses predicted
// by counting edges of the driven tick waveforms inside each measurement window.
module tb_ro_puf_controller;

  localparam int W   = 16;
  localparam int S   = 2;
  localparam int RB  = 4;
  localparam int PER = W + S + 3;
  localparam int LAT = RB * PER;
  localparam int NT  = LAT + 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] challenge = '0;
  logic [2:0] ro1_sel = '0;
  logic [2:0] ro2_sel = '0;
  logic [7:0] ro_tick = '0;

  logic [3:0] sel_seed, sel_seed_s;
  logic       sel_step, sel_step_s;
  logic [7:0] ro_run, ro_run_s;
  logic       busy, busy_s;
  logic [3:0] response, response_s;
  logic       response_valid, response_valid_s;
  logic       tie_flag, tie_flag_s;
  logic       collision_flag, collision_flag_s;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int sel_ptr  = 0;
  logic sel_rewind = 1'b0;

  int half[8];
  int ph[8];
  int pa[RB];
  int pb[RB];

  // observations of the last run
  logic [7:0] o_run[NT];
  logic       o_busy[NT];
  int         o_valid_e, o_valid_n, o_steps;
  logic [3:0] o_resp, o_resp_s, o_seed, o_hold;
  logic       o_tie, o_tie_s, o_coll, o_coll_s;

  // model expectations of the last run
  logic [3:0] e_resp, e_resp_s;
  logic       e_tie, e_tie_s, e_coll;

  ro_puf_controller #(.NUM_RO(8), .SEL_W(3), .CNT_W(8), .WINDOW(W), .SETTLE(S), .RESP_BITS(RB)) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge), .sel_seed(sel_seed),
    .sel_step(sel_step), .ro1_sel(ro1_sel), .ro2_sel(ro2_sel), .ro_tick(ro_tick), .ro_run(ro_run),
    .busy(busy), .response(response), .response_valid(response_valid), .tie_flag(tie_flag),
    .collision_flag(collision_flag));

  ro_puf_controller #(.NUM_RO(8), .SEL_W(3), .CNT_W(3), .WINDOW(W), .SETTLE(S), .RESP_BITS(RB)) dut_s (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge), .sel_seed(sel_seed_s),
    .sel_step(sel_step_s), .ro1_sel(ro1_sel), .ro2_sel(ro2_sel), .ro_tick(ro_tick), .ro_run(ro_run_s),
    .busy(busy_s), .response(response_s), .response_valid(response_valid_s), .tie_flag(tie_flag_s),
    .collision_flag(collision_flag_s));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Selector model: advances to the next scripted pair on each sel_step
  always @(posedge clk) begin
    if (sel_rewind) sel_ptr <= 0;
    else if (sel_step) begin
      ro1_sel <= 3'(pa[sel_ptr % RB]);
      ro2_sel <= 3'(pb[sel_ptr % RB]);
      sel_ptr <= sel_ptr + 1;
    end
  end

  function automatic logic tick_val(int ro, int n);
    if (half[ro] <= 0) return 1'b0;
    return (((n + ph[ro]) / half[ro]) % 2) == 1;
  endfunction

  // RO bank model: tick levels are a pure function of the cycle number
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) ro_tick[i] = tick_val(i, cyc);
  end

  function automatic int rises(int ro, int lo, int hi);
    int c = 0;
    for (int j = lo; j <= hi; j++)
      if (tick_val(ro, j) && !tick_val(ro, j - 1)) c++;
    return c;
  endfunction

  // A level driven in cycle j is seen as an edge two flops later, so the window of bit k
  // covers tick cycles a+PER*k+S+1 .. a+PER*k+S+W relative to the accepting cycle a.
  task automatic model_run(input int a);
    int c1, c2, s1, s2, lo;
    e_resp = '0; e_resp_s = '0; e_tie = 1'b0; e_tie_s = 1'b0; e_coll = 1'b0;
    for (int k = 0; k < RB; k++) begin
      lo = a + PER * k + S + 1;
      c1 = rises(pa[k], lo, lo + W - 1);
      c2 = rises(pb[k], lo, lo + W - 1);
      s1 = (c1 > 7) ? 7 : c1;
      s2 = (c2 > 7) ? 7 : c2;
      if (pa[k] == pb[k]) e_coll = 1'b1;
      e_resp   = {e_resp[2:0], 1'(c1 > c2)};
      e_resp_s = {e_resp_s[2:0], 1'(s1 > s2)};
      if (c1 == c2) e_tie = 1'b1;
      if (s1 == s2) e_tie_s = 1'b1;
    end
  endtask

  function automatic logic [7:0] exp_run(int e);
    int r;
    if (e < 0 || e >= LAT) return '0;
    r = e % PER;
    if (r >= 2 && r < 2 + S + W) return 8'(1 << pa[e / PER]) | 8'(1 << pb[e / PER]);
    return '0;
  endfunction

  // Issue one challenge and record what both controllers do, cycle by cycle
  task automatic run_challenge(input logic [3:0] ch, input int restart_at, input int rst_at);
    int a;
    o_valid_e = -1; o_valid_n = 0; o_steps = 0;
    o_resp = 'x; o_resp_s = 'x; o_tie = 'x; o_tie_s = 'x; o_coll = 'x; o_coll_s = 'x;
    sel_rewind = 1'b1;
    @(negedge clk);
    sel_rewind = 1'b0;
    challenge  = ch;
    start      = 1'b1;
    a = cyc;
    model_run(a);
    for (int e = 0; e < NT; e++) begin
      @(negedge clk);
      start     = (e == restart_at);
      challenge = 4'($urandom);
      if (e == rst_at) reset = 1'b1;
      else if (e == rst_at + 1) reset = 1'b0;
      o_run[e]  = ro_run;
      o_busy[e] = busy;
      if (sel_step) o_steps++;
      if (response_valid) begin
        o_valid_n++;
        if (o_valid_e < 0) begin
          o_valid_e = e;
          o_resp = response; o_tie = tie_flag; o_coll = collision_flag;
          o_resp_s = response_s; o_tie_s = tie_flag_s; o_coll_s = collision_flag_s;
        end
      end
      if (e == 0) o_seed = sel_seed;
      if (e == LAT + 2) o_hold = response;
    end
    start = 1'b0;
  endtask

  task automatic cfg_basic();
    for (int i = 0; i < 8; i++) begin
      half[i] = (i % 2 == 1) ? 2 : 4;
      ph[i]   = 0;
    end
    pa = '{1, 3, 5, 7};
    pb = '{2, 4, 6, 0};
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    reset = 1'b1; start = 1'b1; challenge = 4'hF;
    repeat (3) @(negedge clk);
    obs = {sel_seed, sel_step, ro_run, busy, response, response_valid, tie_flag, collision_flag};
    n_checks++;
    if (obs !== 24'h0) $display("FAIL reset_outputs: got %h expected 000000", obs);
    else n_pass++;
    n_checks++;
    if ({busy_s, ro_run_s, response_valid_s} !== 10'h0)
      $display("FAIL reset_outputs_s: got %h expected 000", {busy_s, ro_run_s, response_valid_s});
    else n_pass++;
    reset = 1'b0;
    n_checks++;
    if ({busy, sel_step} !== 2'b00) $display("FAIL reset_start_held: got %b expected 00", {busy, sel_step});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, sel_step, sel_seed} !== 6'b11_1111)
      $display("FAIL start_after_reset: got %b expected 111111", {busy, sel_step, sel_seed});
    else n_pass++;
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, ro_run} !== 9'h0) $display("FAIL idle_after_reset: got %h expected 000", {busy, ro_run});
    else n_pass++;
  endtask

  task automatic test_basic();
    int bad = 0;
    cfg_basic();
    run_challenge(4'hA, -1, -1);
    n_checks++;
    if (o_seed !== 4'hA) $display("FAIL basic_seed: got %h expected a", o_seed); else n_pass++;
    n_checks++;
    if (o_steps !== RB) $display("FAIL basic_steps: got %0d expected %0d", o_steps, RB); else n_pass++;
    for (int e = 2; e < 2 + S + W; e++) if (o_run[e] !== 8'b0000_0110) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL basic_run_window0: %0d cycles differ from 00000110", bad); else n_pass++;
    bad = 0;
    for (int e = 0; e < NT; e++) if (o_run[e] !== exp_run(e) || o_busy[e] !== (e <= LAT)) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL basic_run_busy_trace: %0d cycles differ", bad); else n_pass++;
    n_checks++;
    if (o_valid_e != LAT || o_valid_n != 1)
      $display("FAIL basic_latency: valid at %0d (x%0d) expected %0d (x1)", o_valid_e + 1, o_valid_n, LAT + 1);
    else n_pass++;
    n_checks++;
    if (o_resp !== 4'b1111 || o_resp !== e_resp)
      $display("FAIL basic_response: got %b expected 1111 (model %b)", o_resp, e_resp);
    else n_pass++;
    n_checks++;
    if (o_hold !== 4'b1111) $display("FAIL basic_hold: got %b expected 1111", o_hold); else n_pass++;
    n_checks++;
    if ({o_tie, o_coll} !== 2'b00) $display("FAIL basic_flags: got %b expected 00", {o_tie, o_coll});
    else n_pass++;
  endtask

  task automatic test_swap();
    cfg_basic();
    half[3] = 4; half[7] = 4; half[4] = 2; half[0] = 2;
    run_challenge(4'hA, -1, -1);
    n_checks++;
    if (o_resp !== 4'b1010 || o_resp !== e_resp)
      $display("FAIL swap_response: got %b expected 1010 (model %b)", o_resp, e_resp);
    else n_pass++;
    n_checks++;
    if (o_tie !== 1'b0) $display("FAIL swap_tie: got %b expected 0", o_tie); else n_pass++;
  endtask

  task automatic test_tie();
    int bad = 0;
    for (int i = 0; i < 8; i++) begin half[i] = 3; ph[i] = 0; end
    pa = '{1, 3, 5, 7};
    pb = '{2, 3, 6, 0};
    run_challenge(4'h3, -1, -1);
    n_checks++;
    if ({o_resp, o_tie} !== 5'b0000_1) $display("FAIL tie_response: got %b expected 00001", {o_resp, o_tie});
    else n_pass++;
    n_checks++;
    if (o_coll !== 1'b1 || o_coll !== e_coll) $display("FAIL tie_collision: got %b expected 1", o_coll);
    else n_pass++;
    for (int e = PER + 2; e < PER + 2 + S + W; e++) if (o_run[e] !== 8'b0000_1000) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL collision_run: %0d cycles differ from 00001000", bad); else n_pass++;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8; i++) begin half[i] = 0; ph[i] = 0; end
    half[1] = 1; half[2] = 2;
    pa = '{1, 1, 1, 1};
    pb = '{2, 2, 2, 2};
    run_challenge(4'h6, 30, -1);
    n_checks++;
    if (o_resp_s !== 4'b1111 || o_resp_s !== e_resp_s)
      $display("FAIL saturate_response: got %b expected 1111 (model %b)", o_resp_s, e_resp_s);
    else n_pass++;
    n_checks++;
    if (o_resp !== e_resp) $display("FAIL wide_response: got %b expected %b", o_resp, e_resp); else n_pass++;
    n_checks++;
    if (o_steps != RB || o_valid_n != 1)
      $display("FAIL restart_ignored: steps %0d valids %0d expected %0d 1", o_steps, o_valid_n, RB);
    else n_pass++;
  endtask

  task automatic test_abort();
    int bad = 0;
    for (int i = 0; i < 8; i++) begin half[i] = 3; ph[i] = 0; end
    pa = '{1, 3, 5, 7};
    pb = '{1, 3, 6, 0};
    run_challenge(4'hC, -1, 50);
    n_checks++;
    if ({o_run[51], o_busy[51]} !== 9'h0)
      $display("FAIL abort_next_cycle: got %h expected 000", {o_run[51], o_busy[51]});
    else n_pass++;
    for (int e = 51; e < NT; e++) if (o_run[e] !== 8'h0 || o_busy[e] !== 1'b0) bad++;
    n_checks++;
    if (bad != 0 || o_valid_n != 0)
      $display("FAIL abort_quiet: %0d active cycles, %0d valids expected 0 0", bad, o_valid_n);
    else n_pass++;
    cfg_basic();
    run_challenge(4'h5, -1, -1);
    n_checks++;
    if ({o_seed, o_resp, o_tie, o_coll} !== 10'b0101_1111_00)
      $display("FAIL after_abort: got %b expected 0101111100", {o_seed, o_resp, o_tie, o_coll});
    else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 8; i++) begin
        half[i] = int'($urandom_range(5, 1));
        ph[i]   = int'($urandom_range(9, 0));
      end
      for (int k = 0; k < RB; k++) begin
        pa[k] = int'($urandom_range(7, 0));
        pb[k] = ($urandom_range(3, 0) == 0) ? pa[k] : int'($urandom_range(7, 0));
      end
      run_challenge(4'($urandom), -1, -1);
      n_checks++;
      if ({o_resp, o_tie, o_coll} !== {e_resp, e_tie, e_coll})
        $display("FAIL rand%0d_dut: got %b expected %b", it, {o_resp, o_tie, o_coll}, {e_resp, e_tie, e_coll});
      else n_pass++;
      n_checks++;
      if ({o_resp_s, o_tie_s, o_coll_s} !== {e_resp_s, e_tie_s, e_coll})
        $display("FAIL rand%0d_sat: got %b expected %b", it, {o_resp_s, o_tie_s, o_coll_s}, {e_resp_s, e_tie_s, e_coll});
      else n_pass++;
      bad = 0;
      for (int e = 0; e < NT; e++) if (o_run[e] !== exp_run(e)) bad++;
      n_checks++;
      if (bad != 0 || o_valid_e != LAT)
        $display("FAIL rand%0d_timing: %0d ro_run cycles differ, valid at %0d expected %0d", it, bad, o_valid_e, LAT);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_tie();
    test_saturate();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ro_puf_controller.md
Name: ro_puf_controller

Overview:
- Challenge/response sequencer for the RO PUF array. On `start` it performs RESP_BITS measurements.
- Each measurement:
  - steps the RO selector once (one-cycle pulse on its enable);
  - latches the two selected RO indices;
  - runs only those two ROs;
  - counts their divided-output edges over a fixed window;
  - compares the counts to produce one response bit.
- Bits are shifted into a response word, which is presented with a one-cycle valid pulse.
- Sits between the host/challenge interface and the RO selector plus RO bank.

Parameters:
- NUM_RO, 8, number of ring oscillators (one-hot run vector width).
- SEL_W, 3, RO index width; must satisfy 2**SEL_W == NUM_RO.
- CNT_W, 16, edge counter width.
- WINDOW, 1024, measurement window in clk cycles (>=2).
- SETTLE, 4, cycles the ROs run before counting starts (>=1).
- RESP_BITS, 8, response bits per challenge (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a challenge; sampled only in IDLE.
- challenge  in  4  seed forwarded to the selector LFSR; latched on accepted start.
- sel_seed  out  4  latched challenge, wired to the selector's lfsr_in.
- sel_step  out  1  one-cycle pulse to the selector's enable.
- ro1_sel  in  SEL_W  selector output A.
- ro2_sel  in  SEL_W  selector output B.
- ro_tick  in  NUM_RO  divided RO outputs, asynchronous to clk.
- ro_run  out  NUM_RO  one-hot-pair RO enable.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- response  out  RESP_BITS  response word; valid when response_valid is high.
- response_valid  out  1  one-cycle pulse.
- tie_flag  out  1  sticky per challenge: some bit had cnt1 == cnt2.
- collision_flag  out  1  sticky per challenge: some measurement latched ro1_sel == ro2_sel.

Behaviour:
- Reset (synchronous):
  - state=IDLE; all outputs 0; sel_seed=0.
  - Counters, bit index and shift register are cleared.
  - Reset asserted mid-measurement aborts the operation: no response_valid is issued and ro_run=0 on the next cycle.
- Input synchronisation: each ro_tick bit passes through a 2-FF synchroniser plus a delay FF. A rising edge is sync & ~delayed.
- FSM states and transitions:
  - IDLE: on start=1, latch challenge into sel_seed, clear tie_flag, collision_flag, the shift register and bit_idx, then go to SELECT. start while not in IDLE is ignored.
  - SELECT (1 cycle): sel_step=1; go to LATCH.
  - LATCH (1 cycle):
    - Capture ro1_sel/ro2_sel into idx_a/idx_b; the selector updates on the SELECT edge, so its new values are visible here.
    - Set collision_flag if idx values are equal.
    - Clear cnt1 and cnt2; go to SETTLE.
  - SETTLE (SETTLE cycles):
    - ro_run = (1<<idx_a) | (1<<idx_b).
    - No counting; edges occurring here are discarded.
  - MEASURE (WINDOW cycles):
    - ro_run as in SETTLE.
    - cnt1 increments on each synchronised edge of ro_tick[idx_a]; cnt2 on each edge of ro_tick[idx_b].
    - Each counter saturates at 2**CNT_W-1 and does not wrap.
  - COMPARE (1 cycle):
    - ro_run=0; bit = (cnt1 > cnt2).
    - If equal: bit=0 and tie_flag is set.
    - Shift left: resp = {resp[RESP_BITS-2:0], bit}; the first measured bit ends up as the MSB.
    - If bit_idx == RESP_BITS-1 go to DONE, else increment bit_idx and go to SELECT.
  - DONE (1 cycle): response_valid=1; response holds the final word; go to IDLE.
- Outputs outside their defined states:
  - response holds its value until the next accepted start.
  - busy=0 in IDLE, 1 in every other state.
- Latency: accepted start to response_valid = 1 + RESP_BITS*(WINDOW+SETTLE+3) cycles. This counts the IDLE acceptance cycle through the DONE cycle.
- The phase timer is a single down-counter of width clog2(max(WINDOW,SETTLE)+1). It reloads on every state entry.

Test Plan (WINDOW=16, SETTLE=2, RESP_BITS=4, CNT_W=8; selector modelled by the bench):
- Reset then idle -> all outputs 0; busy=0; ro_run=0. start held high during reset -> no activity until the cycle after reset deasserts.
- challenge=4'hA, start pulse; selector returns (1,2),(3,4),(5,6),(7,0); ro_tick[idx_a] toggles every 2 cycles, ro_tick[idx_b] every 4 cycles:
  - sel_seed=4'hA.
  - Exactly 4 sel_step pulses.
  - ro_run=8'b0000_0110 during the first window.
  - response=4'b1111 on response_valid at cycle 1+4*21=85.
- Same run but with the tick rates swapped for bit 1 and bit 3 -> response=4'b1010; tie_flag=0.
- Both selected ticks identical on every measurement -> response=4'b0000; tie_flag=1. Selector returns (3,3) once -> collision_flag=1 and ro_run=8'b0000_1000 during that window.
- ro_tick[idx_a] toggling every cycle with CNT_W=3 -> cnt1 saturates at 7 and does not wrap. start re-pulsed mid-run -> ignored, no extra sel_step.
- Reset asserted during the MEASURE of bit 2 -> next cycle: IDLE, ro_run=0, busy=0, no response_valid. A new start then completes normally with fresh flags.
